// File: rtl/hdmi_src_sched.sv
// Source scheduler for the HDMI mux: moves the USB/Ethernet select only on frame
// boundaries, blocks reads for a guard window after each move, and can fail over on starvation.
module hdmi_src_sched #(
  parameter int FRAME_BYTES  = 1024,
  parameter int GUARD_CYCLES = 4,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sel_req,
  input  logic                           auto_en,
  input  logic                           usb_empty,
  input  logic                           eth_empty,
  input  logic                           mux_empty_in,
  input  logic                           rd_en_in,
  output logic                           ctrl,
  output logic                           rd_en_out,
  output logic                           empty_out,
  output logic                           switching,
  output logic [$clog2(FRAME_BYTES)-1:0] byte_cnt,
  output logic [7:0]                     switch_cnt
);

  localparam int CW = $clog2(FRAME_BYTES);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE  = CW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    PEND,
    GUARD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] guard_cnt;
  logic [IW-1:0] idle_cnt;
  logic          active_empty;
  logic          other_empty;
  logic          target;
  logic          flip;
  logic          acc;

  // Auto mode only proposes the other source once it has data and ours has starved.
  always_comb begin
    active_empty = ctrl ? eth_empty : usb_empty;
    other_empty  = ctrl ? usb_empty : eth_empty;
    if (auto_en) begin
      target = ((idle_cnt == IDLE_MAX) && !other_empty) ? ~ctrl : ctrl;
    end else begin
      target = sel_req;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en_out = rd_en_in;
    empty_out = mux_empty_in;
    switching = 1'b0;
    flip      = 1'b0;
    case (state)
      RUN: begin
        if (target != ctrl) state_nxt = PEND;
      end
      PEND: begin
        // At the boundary nothing of the next frame may come from the old source.
        if (byte_cnt == '0) begin
          rd_en_out = 1'b0;
          empty_out = 1'b1;
          switching = 1'b1;
        end
        if (target == ctrl) begin
          state_nxt = RUN;
        end else if (byte_cnt == '0) begin
          flip      = 1'b1;
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        rd_en_out = 1'b0;
        empty_out = 1'b1;
        switching = 1'b1;
        if (guard_cnt == GUARD_LAST) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign acc = rd_en_out & ~mux_empty_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ctrl       <= 1'b0;
      guard_cnt  <= '0;
      idle_cnt   <= '0;
      byte_cnt   <= '0;
      switch_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (flip) begin
        ctrl      <= ~ctrl;
        guard_cnt <= '0;
        if (switch_cnt != 8'hFF) switch_cnt <= switch_cnt + 8'd1;
      end else if (state == GUARD) begin
        guard_cnt <= guard_cnt + 1'b1;
      end
      if (acc) begin
        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
      end
      // Starvation is measured per source, so a select change restarts the count.
      if (flip || !active_empty) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
